// File: rtl/seq_arith_unit_pkg.sv
// Shared definitions for the sequential arithmetic unit: operation codes
// and FSM state encodings used by the top level and the mul/div core.
package seq_arith_unit_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative multiply/divide datapath, one operand bit per step.
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture operands a/b and clear accumulator and bit counter
//   step        : perform one iteration
//   op          : OP_MUL selects shift-add, OP_DIV selects restoring divide
//   a, b        : multiplier/multiplicand or dividend/divisor
//   acc_next    : accumulator after the current step (product, or remainder in low bits)
//   shreg_next  : shift register after the current step (quotient for divide)
//   last        : the current step is the final (WIDTH-th) one
module seq_muldiv_core
  import seq_arith_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  op_e                op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   shreg_next,
  output logic               last
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [W2-1:0]    acc;
  logic [W2-1:0]    opnd;
  logic [W2-1:0]    opnd_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    acc_next   = acc;
    shreg_next = shreg;
    opnd_next  = opnd;
    // Restoring divide: shift the next dividend bit into the partial
    // remainder; since remainder < divisor the trial fits in WIDTH+1 bits.
    trial = {acc[WIDTH-1:0], shreg[WIDTH-1]};
    fits  = (trial >= {1'b0, opnd[WIDTH-1:0]});
    diff  = trial - {1'b0, opnd[WIDTH-1:0]};
    if (op == OP_DIV) begin
      acc_next = '0;
      acc_next[WIDTH-1:0] = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      shreg_next = {shreg[WIDTH-2:0], fits};
    end else begin
      // Shift-add: multiplicand moves left, multiplier drains right.
      acc_next   = acc + (shreg[0] ? opnd : '0);
      shreg_next = shreg >> 1;
      opnd_next  = opnd << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      opnd  <= '0;
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      opnd  <= W2'(b);
      shreg <= a;
      cnt   <= '0;
    end else if (step) begin
      acc   <= acc_next;
      opnd  <= opnd_next;
      shreg <= shreg_next;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential unsigned arithmetic unit: add, subtract (1 cycle), shift-add
// multiply and restoring divide (WIDTH cycles). Results are registered and
// held until the next completion.
//   clk, reset   : clock, synchronous active-high reset
//   start        : request pulse, accepted only in IDLE
//   operation    : 00 add, 01 subtract, 10 multiply, 11 divide
//   x, y         : operands (dividend, divisor)
//   busy         : iteration in progress
//   done         : one-cycle pulse, outputs valid
//   result       : sum / difference / product / quotient
//   remainder    : divide remainder, else zero
//   carry        : add carry-out or subtract borrow
//   hi_nz        : product upper half nonzero, or divide remainder nonzero
//   div_zero     : divide by zero requested
module seq_arith_unit
  import seq_arith_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         operation,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic               carry,
  output logic               hi_nz,
  output logic               div_zero
);

  localparam int unsigned W2 = 2 * WIDTH;

  state_e state, state_next;
  op_e    op_in, op_q;

  logic             core_load, core_step, core_last;
  logic [W2-1:0]    core_acc;
  logic [WIDTH-1:0] core_shreg;

  logic [WIDTH:0]   sum;
  logic [W2-1:0]    sub_diff;

  logic             update;
  logic [W2-1:0]    result_n;
  logic [WIDTH-1:0] remainder_n;
  logic             carry_n, hi_nz_n, div_zero_n;

  assign op_in    = op_e'(operation);
  assign sum      = {1'b0, x} + {1'b0, y};
  assign sub_diff = W2'(x) - W2'(y);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (core_load),
    .step       (core_step),
    .op         (op_q),
    .a          (x),
    .b          (y),
    .acc_next   (core_acc),
    .shreg_next (core_shreg),
    .last       (core_last)
  );

  always_comb begin
    state_next  = state;
    core_load   = 1'b0;
    core_step   = 1'b0;
    update      = 1'b0;
    result_n    = '0;
    remainder_n = '0;
    carry_n     = 1'b0;
    hi_nz_n     = 1'b0;
    div_zero_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (op_in)
            OP_ADD: begin
              state_next = DONE;
              update     = 1'b1;
              result_n   = W2'(sum);
              carry_n    = sum[WIDTH];
            end
            OP_SUB: begin
              state_next = DONE;
              update     = 1'b1;
              result_n   = sub_diff;
              carry_n    = (y > x);
            end
            OP_MUL: begin
              state_next = RUN;
              core_load  = 1'b1;
            end
            OP_DIV: begin
              if (y == '0) begin
                state_next  = DONE;
                update      = 1'b1;
                result_n[WIDTH-1:0] = '1;
                remainder_n = x;
                div_zero_n  = 1'b1;
              end else begin
                state_next = RUN;
                core_load  = 1'b1;
              end
            end
          endcase
        end
      end
      RUN: begin
        core_step = 1'b1;
        if (core_last) begin
          // Outputs take the core's post-step values so the final
          // iteration and the DONE entry share one edge.
          state_next = DONE;
          update     = 1'b1;
          if (op_q == OP_DIV) begin
            result_n    = W2'(core_shreg);
            remainder_n = core_acc[WIDTH-1:0];
            hi_nz_n     = |core_acc[WIDTH-1:0];
          end else begin
            result_n = core_acc;
            hi_nz_n  = |core_acc[W2-1:WIDTH];
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_ADD;
      result    <= '0;
      remainder <= '0;
      carry     <= 1'b0;
      hi_nz     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) op_q <= op_in;
      if (update) begin
        result    <= result_n;
        remainder <= remainder_n;
        carry     <= carry_n;
        hi_nz     <= hi_nz_n;
        div_zero  <= div_zero_n;
      end
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit (WIDTH=4): directed vectors with
// hand-computed results, plus reset-abort and ignored-start scenarios.
module tb_seq_arith_unit;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     operation = '0;
  logic [W-1:0]   x = '0;
  logic [W-1:0]   y = '0;
  logic           busy, done, carry, hi_nz, div_zero;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;

  typedef struct {
    logic [7:0] res;
    logic [3:0] rem;
    logic       c;
    logic       h;
    logic       dz;
    int         lat;
    int         issue;
  } exp_t;

  exp_t sb[$];
  exp_t prev;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cnt = 0;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operation (operation),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .remainder (remainder),
    .carry     (carry),
    .hi_nz     (hi_nz),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        check("hold_result_busy", 32'(result), 32'(prev.res));
        check("hold_rem_busy", 32'(remainder), 32'(prev.rem));
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = sb.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("remainder", 32'(remainder), 32'(e.rem));
          check("carry", 32'(carry), 32'(e.c));
          check("hi_nz", 32'(hi_nz), 32'(e.h));
          check("div_zero", 32'(div_zero), 32'(e.dz));
          check("latency", 32'(cyc - e.issue), 32'(e.lat));
          check("busy_cycles", 32'(busy_cnt), 32'(e.lat - 1));
          prev = e;
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'(0));
    sb.delete();
  endtask

  task automatic push_exp(input logic [7:0] r, input logic [3:0] m,
                          input logic c, input logic h, input logic dz, input int lat);
    exp_t e;
    e.res = r; e.rem = m; e.c = c; e.h = h; e.dz = dz; e.lat = lat; e.issue = cyc;
    sb.push_back(e);
  endtask

  task automatic scramble();
    operation = 2'($urandom);
    x = 4'($urandom);
    y = 4'($urandom);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] r, input logic [3:0] m,
                        input logic c, input logic h, input logic dz, input int lat);
    @(negedge clk);
    operation = op; x = a; y = b; start = 1'b1;
    push_exp(r, m, c, h, dz, lat);
    @(negedge clk);
    start = 1'b0;
    scramble();
    wait_drain();
    repeat (2) begin
      @(negedge clk);
      scramble();
    end
    #1;
    check("idle_hold_result", 32'(result), 32'(r));
    check("idle_hold_rem", 32'(remainder), 32'(m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    prev = '{default: '0};
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_remainder", 32'(remainder), 32'(0));
    check("rst_carry", 32'(carry), 32'(0));
    check("rst_hi_nz", 32'(hi_nz), 32'(0));
    check("rst_div_zero", 32'(div_zero), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    //     op    x   y   result  rem c  h  dz lat
    run_op(2'd0, 9,  8,  8'h11,  0,  1, 0, 0, 1);
    run_op(2'd0, 0,  0,  8'h00,  0,  0, 0, 0, 1);
    run_op(2'd0, 15, 15, 8'h1E,  0,  1, 0, 0, 1);
    run_op(2'd0, 7,  8,  8'h0F,  0,  0, 0, 0, 1);
    run_op(2'd1, 3,  5,  8'hFE,  0,  1, 0, 0, 1);
    run_op(2'd1, 5,  3,  8'h02,  0,  0, 0, 0, 1);
    run_op(2'd1, 0,  15, 8'hF1,  0,  1, 0, 0, 1);
    run_op(2'd1, 9,  9,  8'h00,  0,  0, 0, 0, 1);
    run_op(2'd2, 15, 15, 8'hE1,  0,  0, 1, 0, 5);
    run_op(2'd2, 3,  2,  8'h06,  0,  0, 0, 0, 5);
    run_op(2'd2, 0,  13, 8'h00,  0,  0, 0, 0, 5);
    run_op(2'd2, 4,  4,  8'h10,  0,  0, 1, 0, 5);
    run_op(2'd2, 5,  3,  8'h0F,  0,  0, 0, 0, 5);
    run_op(2'd2, 13, 11, 8'h8F,  0,  0, 1, 0, 5);
    run_op(2'd3, 13, 4,  8'h03,  1,  0, 1, 0, 5);
    run_op(2'd3, 9,  0,  8'h0F,  9,  0, 0, 1, 1);
    run_op(2'd3, 15, 1,  8'h0F,  0,  0, 0, 0, 5);
    run_op(2'd3, 3,  7,  8'h00,  3,  0, 1, 0, 5);
    run_op(2'd3, 15, 15, 8'h01,  0,  0, 0, 0, 5);
    run_op(2'd3, 14, 3,  8'h04,  2,  0, 1, 0, 5);
    run_op(2'd3, 0,  0,  8'h0F,  0,  0, 0, 1, 1);
    run_op(2'd3, 0,  5,  8'h00,  0,  0, 0, 0, 5);

    // start held into the DONE cycle must not launch a second operation
    @(negedge clk);
    operation = 2'd0; x = 4'd2; y = 4'd3; start = 1'b1;
    push_exp(8'h05, 0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);

    // second start during a divide is ignored
    @(negedge clk);
    operation = 2'd3; x = 4'd13; y = 4'd4; start = 1'b1;
    push_exp(8'h03, 1, 0, 1, 0, 5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    operation = 2'd0; x = 4'd1; y = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    #1;
    check("ignored_start_result", 32'(result), 32'(8'h03));
    check("ignored_start_rem", 32'(remainder), 32'(1));

    // reset in the middle of a multiply: no done, outputs back to zero
    @(negedge clk);
    operation = 2'd2; x = 4'd15; y = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    prev = '{default: '0};
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_result", 32'(result), 32'(0));
    check("abort_remainder", 32'(remainder), 32'(0));
    check("abort_carry", 32'(carry), 32'(0));
    check("abort_hi_nz", 32'(hi_nz), 32'(0));
    check("abort_div_zero", 32'(div_zero), 32'(0));
    repeat (8) @(negedge clk);

    // unit still works after the abort
    run_op(2'd2, 6, 7, 8'h2A, 0, 0, 1, 0, 5);

    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
